// File: rtl/shift_add_multiplier.sv
// Sequential unsigned shift-add multiplier.
// A combinational adder sums the upper half of the partial-product register
// with the multiplicand, gated by the current multiplier bit. Each iteration
// shifts {cout, sum, P[W-1:1]} back into the partial-product register.
// After WIDTH iterations the register holds a*b.

module adder #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // Full-width add; the carry-out becomes the next partial-product MSB.
    assign {cout, sum} = a + b;

endmodule

module shift_add_multiplier #(
    parameter int WIDTH = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH) + 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_mcand;
    logic [2*WIDTH-1:0] r_p;
    logic [CW-1:0]      r_count;
    logic [2*WIDTH-1:0] r_product;

    logic [WIDTH-1:0]   w_add_b;
    logic [WIDTH-1:0]   w_sum;
    logic               w_cout;
    logic [2*WIDTH-1:0] w_p_next;
    logic               w_last;
    logic               w_accept;

    // Multiplicand is added only when the multiplier bit at P[0] is set.
    assign w_add_b  = r_p[0] ? r_mcand : '0;
    assign w_p_next = {w_cout, w_sum, r_p[WIDTH-1:1]};
    assign w_last   = (r_count == CW'(WIDTH - 1));
    // New operands are taken only when no iteration is in flight.
    assign w_accept = start && ((r_state == S_IDLE) || (r_state == S_DONE));

    adder #(
        .WIDTH(WIDTH)
    ) u_adder (
        .a    (r_p[2*WIDTH-1:WIDTH]),
        .b    (w_add_b),
        .sum  (w_sum),
        .cout (w_cout)
    );

    // Control state, operand capture and iteration of the partial product.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_mcand   <= '0;
            r_p       <= '0;
            r_count   <= '0;
            r_product <= '0;
        end else begin
            case (r_state)
                S_RUN: begin
                    r_p     <= w_p_next;
                    r_count <= r_count + 1'b1;
                    if (w_last) begin
                        r_state   <= S_DONE;
                        r_product <= w_p_next;
                    end
                end
                default: begin
                    // IDLE and DONE behave identically so DONE can chain
                    // straight into the next operation.
                    if (w_accept) begin
                        r_state <= S_RUN;
                        r_mcand <= a;
                        r_p     <= {{WIDTH{1'b0}}, b};
                        r_count <= '0;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    // Status outputs come straight from the registered state.
    assign busy    = (r_state == S_RUN);
    assign done    = (r_state == S_DONE);
    assign product = r_product;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// Directed and exhaustive checks for shift_add_multiplier (WIDTH=5).
// Inputs are driven and outputs sampled on the falling clock edge.

module tb_shift_add_multiplier;

    localparam int W = 5;

    logic           clk;
    logic           reset;
    logic           start;
    logic [W-1:0]   a;
    logic [W-1:0]   b;
    logic           busy;
    logic           done;
    logic [2*W-1:0] product;

    int checks;
    int errors;

    shift_add_multiplier #(
        .WIDTH(W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .start   (start),
        .a       (a),
        .b       (b),
        .busy    (busy),
        .done    (done),
        .product (product)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse start for one cycle with the given operands, then follow the
    // operation until done is seen (bounded). Leaves the bench on the
    // falling edge where done was observed.
    task automatic do_op(input logic [W-1:0] va, input logic [W-1:0] vb,
                         output logic [2*W-1:0] prod, output int busy_n,
                         output bit got_done);
        @(negedge clk);
        a = va;
        b = vb;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        busy_n = 0;
        got_done = 1'b0;
        prod = 'x;
        for (int i = 0; i < 20 && !got_done; i++) begin
            if (busy) busy_n++;
            if (done) begin
                got_done = 1'b1;
                prod = product;
            end else begin
                @(negedge clk);
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        start = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL reset_done got %b want 0", done);
        end
        checks++;
        if (product !== '0) begin
            errors++;
            $display("FAIL reset_product got %0d want 0", product);
        end
        reset = 1'b0;
        @(negedge clk);
        $display("test_reset: busy=%b done=%b product=%0d", busy, done, product);
    endtask

    task automatic test_single();
        logic [2*W-1:0] p;
        int             bn;
        bit             gd;
        do_op(5'd5, 5'd3, p, bn, gd);
        checks++;
        if (p !== 10'd15) begin
            errors++;
            $display("FAIL single_product got %0d want 15", p);
        end
        checks++;
        if (bn !== 5) begin
            errors++;
            $display("FAIL single_busy_cycles got %0d want 5", bn);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL single_done_width got %b want 0", done);
        end
        repeat (9) @(negedge clk);
        checks++;
        if (product !== 10'd15) begin
            errors++;
            $display("FAIL single_product_hold got %0d want 15", product);
        end
        $display("test_single: 5*3 product=%0d busy_cycles=%0d", p, bn);
    endtask

    task automatic test_max();
        logic [W-1:0]   va [3] = '{5'd31, 5'd31, 5'd0};
        logic [W-1:0]   vb [3] = '{5'd31, 5'd1, 5'd31};
        logic [2*W-1:0] ve [3] = '{10'd961, 10'd31, 10'd0};
        logic [2*W-1:0] p;
        int             bn;
        bit             gd;
        for (int i = 0; i < 3; i++) begin
            do_op(va[i], vb[i], p, bn, gd);
            checks++;
            if (p !== ve[i]) begin
                errors++;
                $display("FAIL max_product[%0d] got %0d want %0d", i, p, ve[i]);
            end
            checks++;
            if (bn !== 5) begin
                errors++;
                $display("FAIL max_busy_cycles[%0d] got %0d want 5", i, bn);
            end
            $display("test_max: %0d*%0d product=%0d busy_cycles=%0d", va[i], vb[i], p, bn);
        end
    endtask

    task automatic test_back_to_back();
        int             done_at [2];
        logic [2*W-1:0] done_p  [2];
        int             nd;
        nd = 0;
        done_at[0] = -1;
        done_at[1] = -1;
        done_p[0] = 'x;
        done_p[1] = 'x;
        @(negedge clk);
        a = 5'd7;
        b = 5'd9;
        start = 1'b1;
        for (int c = 0; c < 30 && nd < 2; c++) begin
            @(negedge clk);
            if (done) begin
                done_at[nd] = c;
                done_p[nd] = product;
                nd++;
                if (nd == 1) begin
                    a = 5'd12;
                    b = 5'd10;
                end else begin
                    start = 1'b0;
                end
            end
        end
        start = 1'b0;
        checks++;
        if (done_p[0] !== 10'd63) begin
            errors++;
            $display("FAIL b2b_product0 got %0d want 63", done_p[0]);
        end
        checks++;
        if (done_p[1] !== 10'd120) begin
            errors++;
            $display("FAIL b2b_product1 got %0d want 120", done_p[1]);
        end
        checks++;
        if (done_at[1] - done_at[0] !== 6) begin
            errors++;
            $display("FAIL b2b_spacing got %0d want 6", done_at[1] - done_at[0]);
        end
        $display("test_back_to_back: products %0d,%0d spacing=%0d",
                 done_p[0], done_p[1], done_at[1] - done_at[0]);
    endtask

    task automatic test_start_during_busy();
        int             bn;
        bit             gd;
        logic [2*W-1:0] p;
        bn = 0;
        gd = 1'b0;
        p = 'x;
        @(negedge clk);
        a = 5'd6;
        b = 5'd6;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 20 && !gd; i++) begin
            if (busy) bn++;
            if (done) begin
                gd = 1'b1;
                p = product;
            end else begin
                // On the second busy cycle, try to start a new op.
                start = (bn == 2);
                a = (bn == 2) ? 5'd1 : 5'd6;
                b = (bn == 2) ? 5'd1 : 5'd6;
                @(negedge clk);
                start = 1'b0;
            end
        end
        checks++;
        if (p !== 10'd36) begin
            errors++;
            $display("FAIL busy_start_product got %0d want 36", p);
        end
        checks++;
        if (bn !== 5) begin
            errors++;
            $display("FAIL busy_start_cycles got %0d want 5", bn);
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL busy_start_idle got %b want 0", busy);
        end
        $display("test_start_during_busy: product=%0d busy_cycles=%0d", p, bn);
    endtask

    task automatic test_reset_mid();
        int             ndone;
        logic [2*W-1:0] p;
        int             bn;
        bit             gd;
        @(negedge clk);
        a = 5'd20;
        b = 5'd20;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL midreset_busy got %b want 0", busy);
        end
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL midreset_done got %b want 0", done);
        end
        checks++;
        if (product !== '0) begin
            errors++;
            $display("FAIL midreset_product got %0d want 0", product);
        end
        ndone = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        checks++;
        if (ndone !== 0) begin
            errors++;
            $display("FAIL midreset_no_done got %0d pulses want 0", ndone);
        end
        do_op(5'd2, 5'd3, p, bn, gd);
        checks++;
        if (p !== 10'd6) begin
            errors++;
            $display("FAIL midreset_next_product got %0d want 6", p);
        end
        $display("test_reset_mid: after reset product=0, next 2*3=%0d", p);
    endtask

    task automatic test_exhaustive();
        logic [2*W-1:0] p;
        logic [2*W-1:0] exp_p;
        int             bn;
        bit             gd;
        int             errs_before;
        errs_before = errors;
        for (int ia = 0; ia < (1 << W); ia++) begin
            for (int ib = 0; ib < (1 << W); ib++) begin
                do_op(W'(ia), W'(ib), p, bn, gd);
                exp_p = (2*W)'(ia * ib);
                checks++;
                if (p !== exp_p || bn !== W) begin
                    errors++;
                    $display("FAIL exhaustive %0d*%0d got %0d (busy %0d) want %0d (busy %0d)",
                             ia, ib, p, bn, exp_p, W);
                end
            end
        end
        $display("test_exhaustive: %0d pairs, %0d errors", 1 << (2*W), errors - errs_before);
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_single();
        test_max();
        test_back_to_back();
        test_start_during_busy();
        test_reset_mid();
        test_exhaustive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
